// File: rtl/pa_fpu_pkg.sv
// rtl/pa_fpu_pkg.sv - FPU shared types: operation codes, CPU-interface states, register map
package pa_fpu;

  typedef enum logic [3:0] {
    op_add  = 4'd0,
    op_sub  = 4'd1,
    op_mul  = 4'd2,
    op_div  = 4'd3,
    op_sqrt = 4'd4,
    op_abs  = 4'd5,
    op_neg  = 4'd6,
    op_cmp  = 4'd7,
    op_log  = 4'd8,
    op_exp  = 4'd9
  } e_fpu_operation;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_START = 2'd1,
    IF_WAIT  = 2'd2
  } e_fpu_if_state;

  localparam logic [3:0] FPU_REG_A0   = 4'h0;
  localparam logic [3:0] FPU_REG_A1   = 4'h1;
  localparam logic [3:0] FPU_REG_A2   = 4'h2;
  localparam logic [3:0] FPU_REG_A3   = 4'h3;
  localparam logic [3:0] FPU_REG_B0   = 4'h4;
  localparam logic [3:0] FPU_REG_B1   = 4'h5;
  localparam logic [3:0] FPU_REG_B2   = 4'h6;
  localparam logic [3:0] FPU_REG_B3   = 4'h7;
  localparam logic [3:0] FPU_REG_OP   = 4'h8;
  localparam logic [3:0] FPU_REG_CMD  = 4'h9;
  localparam logic [3:0] FPU_REG_RES0 = 4'hC;
  localparam logic [3:0] FPU_REG_RES1 = 4'hD;
  localparam logic [3:0] FPU_REG_RES2 = 4'hE;
  localparam logic [3:0] FPU_REG_RES3 = 4'hF;

  localparam int FPU_ST_BUSY     = 0;
  localparam int FPU_ST_DONE     = 1;
  localparam int FPU_ST_ERR_BUSY = 2;
  localparam int FPU_ST_ERR_OP   = 3;
  localparam int FPU_ST_TIMEOUT  = 4;

endpackage

// File: rtl/fpu_cpu_if.sv
// rtl/fpu_cpu_if.sv - CPU register window and launch/watchdog sequencer for the FPU core
// Optional completion interrupt enabled by defining FPU_IRQ_EN.
module fpu_cpu_if
  import pa_fpu::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           cs,
  input  logic           wr,
  input  logic           rd,
  input  logic [3:0]     addr,
  input  logic [7:0]     data_in,
  output logic [7:0]     data_out,
  output logic [31:0]    core_a,
  output logic [31:0]    core_b,
  output e_fpu_operation core_op,
  output logic           core_start,
  input  logic           core_done,
  input  logic [31:0]    core_result,
  output logic           irq
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  e_fpu_if_state state, state_nxt;
  logic [31:0]   a_q, b_q, res_q;
  logic [3:0]    op_q;
  logic [CW-1:0] cnt;
  logic          st_done, st_err_busy, st_err_op, st_timeout;
  logic          busy, wr_en, stat_rd, cmd_go;
  logic          launch, bad_op, got_done, got_timeout;

  assign wr_en      = cs & wr;
  assign stat_rd    = cs & rd & (addr == FPU_REG_OP);
  assign busy       = (state != IF_IDLE);
  assign cmd_go     = wr_en & (addr == FPU_REG_CMD) & data_in[0];
  assign core_a     = a_q;
  assign core_b     = b_q;
  assign core_op    = e_fpu_operation'(op_q);
  assign core_start = (state == IF_START);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IF_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    launch      = 1'b0;
    bad_op      = 1'b0;
    got_done    = 1'b0;
    got_timeout = 1'b0;
    unique case (state)
      IF_IDLE: begin
        if (cmd_go) begin
          if (op_q > 4'(op_exp)) begin
            bad_op = 1'b1;
          end else begin
            launch    = 1'b1;
            state_nxt = IF_START;
          end
        end
      end
      IF_START: state_nxt = IF_WAIT;
      IF_WAIT: begin
        // a done arriving on the final watchdog cycle still counts as success
        if (core_done) begin
          got_done  = 1'b1;
          state_nxt = IF_IDLE;
        end else if (cnt == CNT_MAX) begin
          got_timeout = 1'b1;
          state_nxt   = IF_IDLE;
        end
      end
      default: state_nxt = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      cnt         <= '0;
      st_done     <= 1'b0;
      st_err_busy <= 1'b0;
      st_err_op   <= 1'b0;
      st_timeout  <= 1'b0;
    end else begin
      if (state == IF_START)                      cnt <= '0;
      else if (state == IF_WAIT && cnt != CNT_MAX) cnt <= cnt + CW'(1);

      if (stat_rd) begin
        st_done     <= 1'b0;
        st_err_busy <= 1'b0;
        st_err_op   <= 1'b0;
        st_timeout  <= 1'b0;
      end

      // operands and op stay frozen toward the core while a launch is in flight
      if (wr_en && addr <= FPU_REG_CMD) begin
        if (busy) begin
          st_err_busy <= 1'b1;
        end else begin
          case (addr[3:2])
            2'd0:    a_q[{addr[1:0], 3'b000} +: 8] <= data_in;
            2'd1:    b_q[{addr[1:0], 3'b000} +: 8] <= data_in;
            default: if (addr == FPU_REG_OP) op_q <= data_in[3:0];
          endcase
        end
      end

      if (launch) begin
        st_done     <= 1'b0;
        st_err_busy <= 1'b0;
        st_err_op   <= 1'b0;
        st_timeout  <= 1'b0;
      end
      if (bad_op) st_err_op <= 1'b1;
      if (got_done) begin
        res_q   <= core_result;
        st_done <= 1'b1;
      end
      if (got_timeout) st_timeout <= 1'b1;
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (addr <= FPU_REG_A3)        data_out = a_q[{addr[1:0], 3'b000} +: 8];
    else if (addr <= FPU_REG_B3)   data_out = b_q[{addr[1:0], 3'b000} +: 8];
    else if (addr == FPU_REG_OP)   data_out = {3'b000, st_timeout, st_err_op, st_err_busy, st_done, busy};
    else if (addr >= FPU_REG_RES0) data_out = res_q[{addr[1:0], 3'b000} +: 8];
  end

`ifdef FPU_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                        irq_q <= 1'b0;
    else if (got_done | got_timeout) irq_q <= 1'b1;
    else if (stat_rd)                irq_q <= 1'b0;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_cpu_if.sv
// tb/tb_fpu_cpu_if.sv - self-checking bench for fpu_cpu_if with a register-level reference model
module tb_fpu_cpu_if;
  import pa_fpu::*;

  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           arst = 1'b1;
  logic           cs = 1'b0;
  logic           wr = 1'b0;
  logic           rd = 1'b0;
  logic [3:0]     addr = 4'h0;
  logic [7:0]     data_in = 8'h00;
  logic [7:0]     data_out;
  logic [31:0]    core_a;
  logic [31:0]    core_b;
  e_fpu_operation core_op;
  logic           core_start;
  logic           core_done = 1'b0;
  logic [31:0]    core_result = 32'h0;
  logic           irq;

  fpu_cpu_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .arst(arst), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
    .data_in(data_in), .data_out(data_out), .core_a(core_a), .core_b(core_b),
    .core_op(core_op), .core_start(core_start), .core_done(core_done),
    .core_result(core_result), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_a = 0, m_b = 0, m_res = 0;
  logic [3:0]  m_op = 0;
  logic        m_done = 0, m_eb = 0, m_eo = 0, m_to = 0, m_irq = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_status(input logic busy);
    return {3'b000, m_to, m_eo, m_eb, m_done, busy};
  endfunction

  function automatic logic exp_irq();
`ifdef FPU_IRQ_EN
    return m_irq;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_res = 0; m_op = 0;
    m_done = 0; m_eb = 0; m_eo = 0; m_to = 0; m_irq = 0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d, input logic busy);
    int idx;
    idx = int'(a);
    cs = 1; wr = 1; addr = a; data_in = d;
    cyc();
    cs = 0; wr = 0;
    if (idx <= 9) begin
      if (busy)          m_eb = 1;
      else if (idx <= 3) m_a[idx*8 +: 8] = d;
      else if (idx <= 7) m_b[(idx-4)*8 +: 8] = d;
      else if (idx == 8) m_op = d[3:0];
    end
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = data_out;
  endtask

  task automatic check_state(input string tag, input logic busy);
    logic [7:0] d;
    peek(4'h8, d);
    chk({tag, "_status"}, d, exp_status(busy));
    for (int i = 0; i < 4; i++) begin
      peek(4'(12 + i), d);
      chk($sformatf("%s_res%0d", tag, i), d, m_res[i*8 +: 8]);
    end
    chk({tag, "_irq"}, irq, exp_irq());
  endtask

  task automatic rd_status();
    cs = 1; rd = 1; addr = 4'h8;
    #1;
    chk("status_rd", data_out, exp_status(1'b0));
    cyc();
    cs = 0; rd = 0;
    m_done = 0; m_eb = 0; m_eo = 0; m_to = 0; m_irq = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    for (int i = 0; i < 4; i++) bus_wr(4'(i), a[i*8 +: 8], 1'b0);
    for (int i = 0; i < 4; i++) bus_wr(4'(4 + i), b[i*8 +: 8], 1'b0);
    bus_wr(4'h8, {4'h0, op}, 1'b0);
  endtask

  // j: wait cycle on which core_done is presented (1..16); give=0 lets the watchdog expire
  task automatic launch(input int j, input logic give, input logic [31:0] r, input int wr_addr);
    logic [7:0] d;
    bus_wr(4'h9, 8'h01, 1'b0);
    if (m_op > 4'd9) begin
      m_eo = 1;
      chk("no_start", core_start, 1'b0);
      cyc();
      chk("no_start2", core_start, 1'b0);
      check_state("bad_op", 1'b0);
      return;
    end
    m_done = 0; m_eb = 0; m_eo = 0; m_to = 0;
    chk("start_pulse", core_start, 1'b1);
    chk("start_a", core_a, m_a);
    chk("start_b", core_b, m_b);
    chk("start_op", core_op, m_op);
    cyc();
    chk("start_end", core_start, 1'b0);
    for (int k = 1; k < (give ? j : TMO); k++) begin
      if (wr_addr >= 0 && k == 1) begin
        bus_wr(4'(wr_addr), 8'($urandom), 1'b1);
        chk("held_a", core_a, m_a);
        chk("held_b", core_b, m_b);
        chk("held_op", core_op, m_op);
      end else begin
        peek(4'h8, d);
        chk("busy_status", d, exp_status(1'b1));
        cyc();
      end
    end
    if (give) begin
      core_done = 1; core_result = r;
      cyc();
      core_done = 0;
      m_res = r; m_done = 1; m_irq = 1;
      check_state("done", 1'b0);
    end else begin
      peek(4'h8, d);
      chk("wd_pending", d, exp_status(1'b1));
      cyc();
      m_to = 1; m_irq = 1;
      check_state("timeout", 1'b0);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [31:0] r;
    int j;

    repeat (3) cyc();
    check_state("reset", 1'b0);
    chk("reset_start", core_start, 1'b0);
    chk("reset_a", core_a, 32'h0);
    chk("reset_b", core_b, 32'h0);
    chk("reset_op", core_op, 32'h0);
    arst = 0;
    cyc();

    load(32'h3F800000, 32'h40000000, 4'(op_add));
    launch(5, 1'b1, 32'h40400000, -1);
    peek(4'h8, d);  chk("spec_status", d, 8'h02);
    peek(4'hC, d);  chk("spec_res0", d, 8'h00);
    peek(4'hF, d);  chk("spec_res3", d, 8'h40);
    rd_status();

    launch(6, 1'b1, $urandom, 0);
    peek(4'h8, d);  chk("err_busy_bit", d[2], 1'b1);
    rd_status();

    bus_wr(4'h8, 8'h0F, 1'b0);
    launch(1, 1'b1, 32'h0, -1);
    peek(4'h8, d);  chk("bad_op_status", d, 8'h08);
    rd_status();

    bus_wr(4'h8, 8'(op_mul), 1'b0);
    launch(0, 1'b0, 32'h0, -1);
    rd_status();

    launch(16, 1'b1, $urandom, -1);
    peek(4'h8, d);  chk("edge_status", d, 8'h02);

    core_done = 1; core_result = $urandom;
    cyc();
    core_done = 0;
    check_state("idle_done", 1'b0);

    for (int it = 0; it < 8; it++) begin
      rd_status();
      load($urandom, $urandom, 4'($urandom_range(0, 11)));
      j = $urandom_range(1, 16);
      r = $urandom;
      launch(j, ($urandom_range(0, 3) != 0), r, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 9)) : -1);
    end

    rd_status();
    load($urandom, $urandom, 4'(op_div));
    bus_wr(4'h9, 8'h01, 1'b0);
    cyc();
    cyc();
    arst = 1;
    #1;
    model_reset();
    check_state("arst", 1'b0);
    chk("arst_start", core_start, 1'b0);
    cyc();
    arst = 0;
    cyc();
    core_done = 1; core_result = $urandom;
    cyc();
    core_done = 0;
    check_state("late_done", 1'b0);
    chk("late_start", core_start, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
